// File: rtl/pa_noc.sv
// Shared NoC definitions: packet geometry, field positions and a packet builder.
package pa_noc;

    localparam int PACKET_WIDTH  = 16;
    localparam int COORD_WIDTH   = 2;
    localparam int PAYLOAD_WIDTH = PACKET_WIDTH - 8;

    localparam int DEST_COL_LSB = 0;
    localparam int DEST_ROW_LSB = 2;
    localparam int SRC_COL_LSB  = 4;
    localparam int SRC_ROW_LSB  = 6;
    localparam int PAYLOAD_LSB  = 8;

    // Field order mirrors the wire layout, MSB first.
    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [COORD_WIDTH-1:0]   srcRow;
        logic [COORD_WIDTH-1:0]   srcCol;
        logic [COORD_WIDTH-1:0]   destRow;
        logic [COORD_WIDTH-1:0]   destCol;
    } nocPacket_t;

    function automatic nocPacket_t makePacket(
        input logic [PAYLOAD_WIDTH-1:0] payload,
        input logic [COORD_WIDTH-1:0]   srcRow,
        input logic [COORD_WIDTH-1:0]   srcCol,
        input logic [COORD_WIDTH-1:0]   destRow,
        input logic [COORD_WIDTH-1:0]   destCol
    );
        nocPacket_t p;
        p.payload = payload;
        p.srcRow  = srcRow;
        p.srcCol  = srcCol;
        p.destRow = destRow;
        p.destCol = destCol;
        return p;
    endfunction

endpackage

// File: rtl/synchronousFifo.sv
// First-word-fall-through synchronous FIFO; simultaneous push and pop is legal even when full.
module synchronousFifo #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [WIDTH-1:0]         mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wrPtr;
    logic [ADDRESS_WIDTH-1:0] rdPtr;
    logic [ADDRESS_WIDTH:0]   count;
    logic                     doPush;
    logic                     doPop;

    assign o_full  = (count == (ADDRESS_WIDTH+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign doPop   = i_pop && !o_empty;
    assign doPush  = i_push && (!o_full || doPop);
    assign o_data  = mem[rdPtr];

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    // Storage array write port.
    // NOTE: the memory is deliberately not reset; emptiness is defined by the pointers, so contents are don't-care.
    always_ff @(posedge i_clk) begin
        if (doPush) mem[wrPtr] <= i_data;
    end

endmodule

// File: rtl/network_interface.sv
// Core-to-router adapter: packs and injects TX packets, accepts and checks RX deliveries, keeps status counters.
module network_interface
    import pa_noc::*;
#(
    parameter int GRID_WIDTH         = 4,
    parameter int FIFO_ADDRESS_WIDTH = 2,
    parameter int NI_ROW             = 0,
    parameter int NI_COL             = 0
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic [PAYLOAD_WIDTH-1:0] i_txPayload,
    input  logic [COORD_WIDTH-1:0]   i_txDestRow,
    input  logic [COORD_WIDTH-1:0]   i_txDestCol,
    input  logic                     i_txValid,
    output logic                     o_txReady,
    output logic [PACKET_WIDTH-1:0]  o_router,
    output logic                     o_routerValid,
    input  logic                     i_routerReady,
    input  logic [PACKET_WIDTH-1:0]  i_router,
    input  logic                     i_routerValid,
    output logic                     o_routerReady,
    output logic [PAYLOAD_WIDTH-1:0] o_rxPayload,
    output logic [COORD_WIDTH-1:0]   o_rxSrcRow,
    output logic [COORD_WIDTH-1:0]   o_rxSrcCol,
    output logic                     o_rxValid,
    input  logic                     i_rxReady,
    output logic [15:0]              o_txCount,
    output logic [15:0]              o_rxCount,
    output logic                     o_misroute,
    input  logic                     i_clearStatus
);

    localparam int DEPTH    = 2 ** FIFO_ADDRESS_WIDTH;
    localparam int OCC_W    = FIFO_ADDRESS_WIDTH + 1;
    localparam int RX_WIDTH = PACKET_WIDTH - SRC_COL_LSB;
    localparam logic [COORD_WIDTH-1:0] MY_ROW = COORD_WIDTH'(NI_ROW);
    localparam logic [COORD_WIDTH-1:0] MY_COL = COORD_WIDTH'(NI_COL);

    if ($clog2(GRID_WIDTH) != COORD_WIDTH) begin : gBadGrid
        $error("GRID_WIDTH does not match the packet coordinate width");
    end

    // ---------------- TX path ----------------
    nocPacket_t              txPacket;
    logic [PACKET_WIDTH-1:0] txHead;
    logic                    txFull;
    logic                    txEmpty;
    logic                    txPush;
    logic                    txPop;

    assign txPacket      = makePacket(i_txPayload, MY_ROW, MY_COL, i_txDestRow, i_txDestCol);
    assign o_txReady     = !txFull;
    assign txPush        = i_txValid && !txFull;
    // The router writes on valid alone, so valid must never be raised while it is not ready.
    assign o_routerValid = !txEmpty && i_routerReady;
    assign txPop         = o_routerValid;
    assign o_router      = txEmpty ? '0 : txHead;

    synchronousFifo #(.WIDTH(PACKET_WIDTH), .ADDRESS_WIDTH(FIFO_ADDRESS_WIDTH)) uTxFifo (
        .i_clk   (i_clk),
        .i_arst_n(i_arst_n),
        .i_push  (txPush),
        .i_data  (txPacket),
        .i_pop   (txPop),
        .o_data  (txHead),
        .o_full  (txFull),
        .o_empty (txEmpty)
    );

    // ---------------- RX path ----------------
    logic                readyQ;
    logic                arrival;
    logic                destOk;
    logic                rxPush;
    logic                rxPop;
    logic                rxEmpty;
    logic                unusedRxFull;
    logic [OCC_W-1:0]    rxOccupancy;
    logic [OCC_W-1:0]    rxFree;
    logic [RX_WIDTH-1:0] rxHead;

    // A valid without a committed ready is the router re-presenting the same packet; ignore it.
    assign arrival = i_routerValid && readyQ;
    assign destOk  = (i_router[DEST_ROW_LSB +: COORD_WIDTH] == MY_ROW)
                  && (i_router[DEST_COL_LSB +: COORD_WIDTH] == MY_COL);
    assign rxPush  = arrival && destOk;
    assign rxPop   = o_rxValid && i_rxReady;
    assign rxFree  = OCC_W'(DEPTH) - rxOccupancy;
    // Keep one slot in reserve for a packet the router has already committed.
    assign o_routerReady = (rxFree >= OCC_W'(2)) || ((rxFree == OCC_W'(1)) && !arrival);

    assign o_rxValid   = !rxEmpty;
    assign o_rxPayload = rxHead[PAYLOAD_LSB - SRC_COL_LSB +: PAYLOAD_WIDTH];
    assign o_rxSrcRow  = rxHead[SRC_ROW_LSB - SRC_COL_LSB +: COORD_WIDTH];
    assign o_rxSrcCol  = rxHead[0 +: COORD_WIDTH];

    synchronousFifo #(.WIDTH(RX_WIDTH), .ADDRESS_WIDTH(FIFO_ADDRESS_WIDTH)) uRxFifo (
        .i_clk   (i_clk),
        .i_arst_n(i_arst_n),
        .i_push  (rxPush),
        .i_data  (i_router[PACKET_WIDTH-1:SRC_COL_LSB]),
        .i_pop   (rxPop),
        .o_data  (rxHead),
        .o_full  (unusedRxFull),
        .o_empty (rxEmpty)
    );

    // Delayed ready (what the router committed against) and local RX occupancy.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            readyQ      <= 1'b0;
            rxOccupancy <= '0;
        end else begin
            readyQ <= o_routerReady;
            case ({rxPush, rxPop})
                2'b10:   rxOccupancy <= rxOccupancy + 1'b1;
                2'b01:   rxOccupancy <= rxOccupancy - 1'b1;
                default: rxOccupancy <= rxOccupancy;
            endcase
        end
    end

    // Saturating traffic counters and sticky misroute flag; clear wins over increment.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_txCount  <= '0;
            o_rxCount  <= '0;
            o_misroute <= 1'b0;
        end else if (i_clearStatus) begin
            o_txCount  <= '0;
            o_rxCount  <= '0;
            o_misroute <= 1'b0;
        end else begin
            if (txPop && (o_txCount != 16'hFFFF))  o_txCount <= o_txCount + 16'd1;
            if (rxPush && (o_rxCount != 16'hFFFF)) o_rxCount <= o_rxCount + 16'd1;
            if (arrival && !destOk)                o_misroute <= 1'b1;
        end
    end

endmodule

// File: tb/tb_network_interface.sv
// Self-checking bench for network_interface: directed scenarios plus randomized traffic against a queue model.
module tb_network_interface;

    localparam int DEPTH = 4;
    localparam int MY_ROW = 1;
    localparam int MY_COL = 2;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  txPayload = '0;
    logic [1:0]  txDestRow = '0;
    logic [1:0]  txDestCol = '0;
    logic        txValid = 1'b0;
    logic        txReady;
    logic [15:0] routerOut;
    logic        routerOutValid;
    logic        routerReady = 1'b0;
    logic [15:0] routerIn = '0;
    logic        routerInValid = 1'b0;
    logic        niReady;
    logic [7:0]  rxPayload;
    logic [1:0]  rxSrcRow;
    logic [1:0]  rxSrcCol;
    logic        rxValid;
    logic        rxReady = 1'b0;
    logic [15:0] txCount;
    logic [15:0] rxCount;
    logic        misroute;
    logic        clearStatus = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [15:0] txQ[$];
    logic [15:0] rxQ[$];
    int          txCnt;
    int          rxCnt;
    bit          misr;
    bit          readyQm;
    bit          readyQd;

    always #5 clk = ~clk;

    network_interface #(
        .GRID_WIDTH(4), .FIFO_ADDRESS_WIDTH(2), .NI_ROW(MY_ROW), .NI_COL(MY_COL)
    ) dut (
        .i_clk(clk), .i_arst_n(rstN),
        .i_txPayload(txPayload), .i_txDestRow(txDestRow), .i_txDestCol(txDestCol),
        .i_txValid(txValid), .o_txReady(txReady),
        .o_router(routerOut), .o_routerValid(routerOutValid), .i_routerReady(routerReady),
        .i_router(routerIn), .i_routerValid(routerInValid), .o_routerReady(niReady),
        .o_rxPayload(rxPayload), .o_rxSrcRow(rxSrcRow), .o_rxSrcCol(rxSrcCol),
        .o_rxValid(rxValid), .i_rxReady(rxReady),
        .o_txCount(txCount), .o_rxCount(rxCount), .o_misroute(misroute),
        .i_clearStatus(clearStatus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] makePkt(input int payload, input int sr, input int sc,
                                            input int dr, input int dc);
        return 16'(payload * 256 + sr * 64 + sc * 16 + dr * 4 + dc);
    endfunction

    // One clock cycle: compare DUT against the model, advance the model, cross one posedge.
    // Entered and left at a negedge with inputs already driven.
    task automatic step();
        int          rxFree;
        bit          arrival;
        bit          arrivalDut;
        bit          expTxReady;
        bit          expRouterValid;
        bit          expNiReady;
        bit          destMatch;
        logic [15:0] dropped;
        #1;
        expTxReady     = txQ.size() < DEPTH;
        expRouterValid = (txQ.size() != 0) && routerReady;
        arrival        = routerInValid && readyQm;
        rxFree         = DEPTH - rxQ.size();
        expNiReady     = (rxFree >= 2) || (rxFree == 1 && !arrival);
        arrivalDut     = routerInValid && readyQd;

        check("txReady", 32'(txReady), 32'(expTxReady));
        check("routerValid", 32'(routerOutValid), 32'(expRouterValid));
        if (expRouterValid) check("routerPacket", 32'(routerOut), 32'(txQ[0]));
        check("niReady", 32'(niReady), 32'(expNiReady));
        check("rxValid", 32'(rxValid), 32'(rxQ.size() != 0));
        if (rxQ.size() != 0) begin
            check("rxPayload", 32'(rxPayload), 32'(rxQ[0] >> 8));
            check("rxSrcRow", 32'(rxSrcRow), 32'((rxQ[0] >> 6) & 16'h3));
            check("rxSrcCol", 32'(rxSrcCol), 32'((rxQ[0] >> 4) & 16'h3));
        end
        check("txCount", 32'(txCount), 32'(txCnt));
        check("rxCount", 32'(rxCount), 32'(rxCnt));
        check("misroute", 32'(misroute), 32'(misr));
        check("rxOverflow", 32'(arrivalDut && rxQ.size() == DEPTH), 32'(0));

        destMatch = (int'((routerIn >> 2) & 16'h3) == MY_ROW) && (int'(routerIn & 16'h3) == MY_COL);
        if (rxQ.size() != 0 && rxReady) dropped = rxQ.pop_front();
        if (arrival && destMatch) rxQ.push_back(routerIn);
        if (expRouterValid) dropped = txQ.pop_front();
        if (txValid && expTxReady)
            txQ.push_back(makePkt(int'(txPayload), MY_ROW, MY_COL, int'(txDestRow), int'(txDestCol)));
        if (clearStatus) begin
            txCnt = 0;
            rxCnt = 0;
            misr  = 1'b0;
        end else begin
            if (expRouterValid && txCnt < 65535) txCnt++;
            if (arrival && destMatch && rxCnt < 65535) rxCnt++;
            if (arrival && !destMatch) misr = 1'b1;
        end
        readyQm = expNiReady;
        readyQd = niReady;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        txValid       = 1'b0;
        routerInValid = 1'b0;
        clearStatus   = 1'b0;
        routerReady   = 1'b1;
        rxReady       = 1'b1;
    endtask

    // Asynchronous reset at a negedge, check reset values, release two cycles later.
    task automatic doReset();
        idleInputs();
        rstN = 1'b0;
        #1;
        check("rst_txReady", 32'(txReady), 32'(1));
        check("rst_routerValid", 32'(routerOutValid), 32'(0));
        check("rst_router", 32'(routerOut), 32'(0));
        check("rst_niReady", 32'(niReady), 32'(1));
        check("rst_rxValid", 32'(rxValid), 32'(0));
        check("rst_txCount", 32'(txCount), 32'(0));
        check("rst_rxCount", 32'(rxCount), 32'(0));
        check("rst_misroute", 32'(misroute), 32'(0));
        txQ.delete();
        rxQ.delete();
        txCnt = 0;
        rxCnt = 0;
        misr = 1'b0;
        readyQm = 1'b0;
        readyQd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic randomCycle();
        int r;
        txValid     = 1'($urandom_range(0, 1));
        txPayload   = 8'($urandom);
        txDestRow   = 2'($urandom);
        txDestCol   = 2'($urandom);
        routerReady = ($urandom_range(0, 3) != 0);
        rxReady     = 1'($urandom_range(0, 1));
        clearStatus = ($urandom_range(0, 63) == 0);
        routerInValid = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 3));
        if (r != 0)
            routerIn = makePkt(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 3)), MY_ROW, MY_COL);
        else
            routerIn = makePkt(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 3)));
        step();
    endtask

    initial begin
        @(negedge clk);
        doReset();

        // Single TX packet: header stamped with source (1,2).
        txValid = 1'b1; txPayload = 8'h5A; txDestRow = 2'd3; txDestCol = 2'd0;
        step();
        txValid = 1'b0;
        #1;
        check("t1_valid", 32'(routerOutValid), 32'(1));
        check("t1_packet", 32'(routerOut), 32'h5A6C);
        step();
        check("t1_txCount", 32'(txCount), 32'(1));

        // TX back-pressure: five requests, four fit.
        routerReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            txValid = 1'b1; txPayload = 8'(8'h10 + i);
            txDestRow = 2'(i); txDestCol = 2'(i + 1);
            step();
        end
        #1;
        check("t2_txReadyLow", 32'(txReady), 32'(0));
        check("t2_noValid", 32'(routerOutValid), 32'(0));
        txValid = 1'b0; routerReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_order", 32'(routerOut), 32'(makePkt(16 + i, MY_ROW, MY_COL, i, (i + 1) % 4)));
            step();
        end
        #1;
        check("t2_drained", 32'(routerOutValid), 32'(0));
        check("t2_txCount", 32'(txCount), 32'(5));

        // Single RX delivery.
        routerIn = makePkt(8'h33, 2, 3, MY_ROW, MY_COL); routerInValid = 1'b1;
        step();
        routerInValid = 1'b0;
        #1;
        check("t3_rxValid", 32'(rxValid), 32'(1));
        check("t3_payload", 32'(rxPayload), 32'h33);
        check("t3_srcRow", 32'(rxSrcRow), 32'(2));
        check("t3_srcCol", 32'(rxSrcCol), 32'(3));
        check("t3_rxCount", 32'(rxCount), 32'(1));
        step();

        // RX back-pressure: valid held high, exactly four stored.
        rxReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            routerIn = makePkt(8'h40 + i, 0, 1, MY_ROW, MY_COL); routerInValid = 1'b1;
            step();
        end
        #1;
        check("t4_niReadyLow", 32'(niReady), 32'(0));
        check("t4_rxCount", 32'(rxCount), 32'(5));
        routerInValid = 1'b0; rxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_order", 32'(rxPayload), 32'(8'h40 + i));
            step();
        end
        #1;
        check("t4_empty", 32'(rxValid), 32'(0));

        // Misroute: dropped, flag sticky until cleared.
        routerIn = makePkt(8'h77, 1, 1, 0, 0); routerInValid = 1'b1;
        step();
        routerInValid = 1'b0;
        #1;
        check("t5_misroute", 32'(misroute), 32'(1));
        check("t5_notStored", 32'(rxValid), 32'(0));
        for (int i = 0; i < 3; i++) step();
        check("t5_sticky", 32'(misroute), 32'(1));
        clearStatus = 1'b1;
        step();
        clearStatus = 1'b0;
        check("t5_cleared", 32'(misroute), 32'(0));
        check("t5_txCleared", 32'(txCount), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) randomCycle();

        // Saturation of the TX counter.
        idleInputs();
        clearStatus = 1'b1;
        step();
        clearStatus = 1'b0;
        txValid = 1'b1; txPayload = 8'hC3; txDestRow = 2'd0; txDestCol = 2'd3;
        for (int i = 0; i < 65540; i++) step();
        check("t6_saturated", 32'(txCount), 32'hFFFF);
        step();
        check("t6_holds", 32'(txCount), 32'hFFFF);

        // Reset in the middle of traffic.
        routerReady = 1'b0;
        routerIn = makePkt(8'h99, 3, 3, MY_ROW, MY_COL); routerInValid = 1'b1; rxReady = 1'b0;
        for (int i = 0; i < 3; i++) step();
        doReset();
        #1;
        check("t7_txEmpty", 32'(routerOutValid), 32'(0));
        check("t7_rxEmpty", 32'(rxValid), 32'(0));
        for (int i = 0; i < 200; i++) randomCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/network_interface.md
# network_interface

Endpoint adapter between a processing core and its router's local (NI) port. It packs core requests into NoC packets, stamps the source coordinates, buffers them, and injects them with the router's valid/ready rules. It also absorbs the router's registered local-delivery output into an RX buffer, checks the destination, and presents the payload to the core over a standard valid/ready interface. It keeps saturating traffic counters and a sticky misroute flag.

## Interface
- GRID_WIDTH, 4: mesh dimension; coordinates are $clog2(GRID_WIDTH) bits, which must equal COORD_WIDTH.
- FIFO_ADDRESS_WIDTH, 2: TX and RX FIFO depth = 2**FIFO_ADDRESS_WIDTH.
- NI_ROW, 0: row of the attached router.
- NI_COL, 0: column of the attached router.
- i_clk  in  1  clock.
- i_arst_n  in  1  reset, asynchronous, active-low.
- i_txPayload  in  PAYLOAD_WIDTH  core payload to send.
- i_txDestRow / i_txDestCol  in  COORD_WIDTH each  destination coordinates.
- i_txValid / o_txReady  in / out  1  core TX handshake.
- o_router / o_routerValid  out  PACKET_WIDTH / 1  packet and valid to the router's NI input.
- i_routerReady  in  1  router NI-input FIFO not full.
- i_router / i_routerValid  in  PACKET_WIDTH / 1  registered delivery from the router.
- o_routerReady  out  1  NI can accept a delivery; the router samples it one cycle before data arrives.
- o_rxPayload  out  PAYLOAD_WIDTH  received payload.
- o_rxSrcRow / o_rxSrcCol  out  COORD_WIDTH each  sender coordinates.
- o_rxValid / i_rxReady  out / in  1  core RX handshake.
- o_txCount / o_rxCount  out  16 each  saturating counts of packets injected and delivered.
- o_misroute  out  1  sticky: a packet was received whose destination is not (NI_ROW, NI_COL).
- i_clearStatus  in  1  synchronous clear of the counters and o_misroute.

## Operation
- Packet layout, LSB first:
  - [1:0] destination column.
  - [3:2] destination row.
  - [5:4] source column (NI_COL).
  - [7:6] source row (NI_ROW).
  - [PACKET_WIDTH-1:8] payload.
- TX path:
  - Write: a TX FIFO write occurs on i_txValid && o_txReady. o_txReady = !txFull.
  - Inject: o_routerValid = !txEmpty && i_routerReady; the TX FIFO pops in the same cycle.
  - o_router = TX FIFO head. Valid is never raised while i_routerReady is low, because the router writes on valid alone.
- RX acceptance rule: the router commits a delivery in cycle c using o_routerReady(c), and presents it at c+1. The NI keeps readyQ = o_routerReady delayed by one cycle.
  - arrival = i_routerValid && readyQ.
  - i_routerValid && !readyQ: the NI ignores it; this is the router re-presenting an uncommitted packet.
- RX ready: rxFree = depth - rxOccupancy.
  - o_routerReady = (rxFree >= 2) || (rxFree == 1 && !arrival).
  - This guarantees a slot for the in-flight packet. Occupancy is tracked by a local counter.
- RX check: on arrival, if the destination field matches (NI_ROW, NI_COL), the packet is pushed to the RX FIFO and o_rxCount increments. Otherwise it is dropped and o_misroute is set.
- RX output: o_rxValid = !rxEmpty; the payload and source fields come from the FIFO head. The FIFO pops on o_rxValid && i_rxReady.
- Counters:
  - o_txCount increments on each injection.
  - Both counters saturate at 16'hFFFF.
  - i_clearStatus has priority over a same-cycle increment; the counter clears to 0.
- Simultaneous push and pop on either FIFO, including when full, is legal. Occupancy is unchanged.

## Timing
- Reset values:
  - o_txReady = 1.
  - o_routerValid = 0, o_router = 0.
  - o_routerReady = 1 (rxFree = depth ≥ 2).
  - o_rxValid = 0.
  - counters = 0, o_misroute = 0, readyQ = 0.
- Reset mid-operation flushes both FIFOs, the occupancy counter and readyQ. In-flight packets are lost.
- TX latency: core handshake at edge k gives o_routerValid in cycle k+1 if i_routerReady is high.
- RX latency: arrival at edge k gives o_rxValid in cycle k+1.
- Arrival into a full RX FIFO is a protocol violation. Bench assertion: it must never occur given the ready rule.

## Structure
- pa_noc holds:
  - PACKET_WIDTH and COORD_WIDTH = 2.
  - PAYLOAD_WIDTH = PACKET_WIDTH - 8.
  - Field LSB constants: DEST_COL_LSB=0, DEST_ROW_LSB=2, SRC_COL_LSB=4, SRC_ROW_LSB=6, PAYLOAD_LSB=8.
- TX and RX buffers are two instances of the existing synchronousFifo (first-word-fall-through). The RX occupancy counter is local. No other sub-module.

## Test plan
- NI at (1,2), payload 0x5A to (3,0), router ready → next cycle o_router has dest=(3,0), src=(1,2), payload 0x5A; o_txCount=1.
- i_routerReady held low, 5 TX requests with depth 4 → 4 accepted, o_txReady=0, no o_routerValid. Release → 4 injections in order on consecutive cycles.
- Router delivers dest=(1,2) payload 0x33 → o_rxValid next cycle with payload 0x33 and the correct source; o_rxCount=1.
- i_rxReady low, back-to-back deliveries → o_routerReady drops when rxFree reaches 1 with an arrival pending. No overflow; exactly 4 stored. i_routerValid while readyQ=0 is not stored.
- Delivery with dest=(0,0) → dropped, o_misroute=1 and held until i_clearStatus.
- Preload o_txCount to 0xFFFF, inject → stays 0xFFFF. Assert i_arst_n low mid-transfer → all outputs at reset values, FIFOs empty.
